// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter: a grant is locked from issue until the
// beat flagged last, and an owner may keep up to its weight of back-to-back bursts.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   req_i              level request per port
//   weight_i           port p weight at [p*WEIGHT_W +: WEIGHT_W]; 0 acts as 1
//   beat_i, last_i     beat accepted from owner / beat is the final one
//   gnt_o, gnt_id_o    one-hot grant and binary owner index
//   busy_o             high while a grant is held
//   timeout_o          one-cycle pulse on forced release
//
// Optional feature macro: WRR_BURST_TIMEOUT_EN (burst watchdog of TIMEOUT_CYC).
module wrr_burst_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int WEIGHT_W    = 3,
  parameter int TIMEOUT_CYC = 64,
  localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
  input  logic                          beat_i,
  input  logic                          last_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic [ID_W-1:0]               gnt_id_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("wrr_burst_arbiter: illegal parameter set");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [WEIGHT_W-1:0] wsel;
  logic [WEIGHT_W-1:0] wload;
  logic [WEIGHT_W-1:0] credit_nx;
  logic [ID_W-1:0]     ptr_inc;
  logic                burst_end;
  logic                tmo_hit;

  // First set request searching ptr, ptr+1, ... modulo NUM_PORTS.
  // Walking backwards lets the lowest offset overwrite the others.
  function automatic logic [ID_W:0] pick(
    input logic [NUM_PORTS-1:0] req,
    input logic [ID_W-1:0]      ptr
  );
    logic [ID_W:0] r;
    int k;
    r = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NUM_PORTS;
      if (req[k]) r = {1'b1, ID_W'(k)};
    end
    return r;
  endfunction

  always_comb begin
    {win_found, win_idx} = pick(req_i, ptr_q);
    wsel      = weight_i[int'(win_idx)*WEIGHT_W +: WEIGHT_W];
    wload     = (wsel == '0) ? WEIGHT_W'(1) : wsel;
    credit_nx = credit_q - WEIGHT_W'(1);
    ptr_inc   = (int'(owner_q) == NUM_PORTS - 1) ? '0
                                                 : owner_q + ID_W'(1);
    burst_end = beat_i && last_i;
  end

`ifdef WRR_BURST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q;

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Counter restarts at every grant and every burst end.
  always_comb begin
    cnt_d = '0;
    if (state_q == GRANT && !burst_end) cnt_d = cnt_q + CNT_W'(1);
  end

  // A last beat in the terminal cycle wins over the watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= (state_q == GRANT) && !burst_end && tmo_hit;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = GRANT;
          owner_d  = win_idx;
          credit_d = wload;
        end
      end
      GRANT: begin
        unique case (1'b1)
          burst_end: begin
            if (credit_nx != '0 && req_i[owner_q]) begin
              credit_d = credit_nx;
            end else begin
              state_d  = IDLE;
              ptr_d    = ptr_inc;
              credit_d = '0;
            end
          end
          tmo_hit: begin
            state_d  = IDLE;
            ptr_d    = ptr_inc;
            credit_d = '0;
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registers; owner index is kept in IDLE.
  always_comb begin
    busy_o   = (state_q == GRANT);
    gnt_id_o = owner_q;
    gnt_o    = '0;
    if (busy_o) gnt_o = NUM_PORTS'(1) << owner_q;
  end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
Weighted round-robin arbiter that shares a single burst-oriented resource, such as a memory port or shared bus, between NUM_PORTS requesters. A grant is locked for a whole burst, from grant to the beat flagged last. A port may hold ownership for up to its programmed weight of back-to-back bursts before the rotating priority pointer moves on. It sits in front of the shared resource mux and is the sequenced successor to the plain round-robin arbiter.

Parameters:
NUM_PORTS, 4, number of requesters; legal range 2..16.
WEIGHT_W, 3, width of each per-port weight field.
TIMEOUT_CYC, 64, cycles a burst may stay in GRANT without a last beat (used only with the optional feature).

Ports:
clk  input  1  single clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
req_i  input  NUM_PORTS  level request per port.
weight_i  input  NUM_PORTS*WEIGHT_W  port p weight at [p*WEIGHT_W +: WEIGHT_W].
beat_i  input  1  resource accepted one beat from the current owner this cycle.
last_i  input  1  qualifies beat_i as the final beat of the burst.
gnt_o  output  NUM_PORTS  registered one-hot grant; all zero when idle.
gnt_id_o  output  $clog2(NUM_PORTS)  binary index of the owner; valid while busy_o=1.
busy_o  output  1  high in GRANT state.
timeout_o  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE, ptr=0, credit=0.
  - gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0.
  - Reset mid-burst drops the grant on the next edge; no completion is signalled.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - If req_i is nonzero, the winner is the first set bit searching ptr, ptr+1, ..., wrapping modulo NUM_PORTS.
  - On the next edge: state=GRANT, gnt_o=onehot(winner), gnt_id_o=winner, busy_o=1.
  - credit is loaded with weight_i[winner]; a weight of 0 is treated as 1.
  - Latency from request to grant, starting in IDLE, is exactly 1 cycle.
  - If req_i=0, the block stays in IDLE.
- GRANT:
  - gnt_o is held constant.
  - req_i[owner] deasserting mid-burst is ignored; the burst lock holds until last.
  - beat_i=0 means no progress. last_i without beat_i is ignored.
  - beat_i=1 with last_i=1 ends the burst; credit_next=credit-1.
  - If credit_next>0 and req_i[owner]=1 in that same cycle: stay in GRANT with the same owner, no bubble cycle, and credit=credit_next.
  - Otherwise, release: on the next edge state=IDLE, gnt_o=0, busy_o=0, ptr=(owner+1) mod NUM_PORTS.
  - The IDLE cycle is a mandatory 1-cycle bubble; re-arbitration happens in it. A release-to-next-grant gap is therefore exactly 1 idle cycle.
- weight_i is sampled only when a grant is issued. Changes during GRANT take effect at the next grant.
- ptr does not move on back-to-back bursts within a credit allotment.
- gnt_id_o holds its last value in IDLE; only busy_o qualifies it.
- A request from a non-owner never preempts the owner.

Optional Feature:
WRR_BURST_TIMEOUT_EN
- Defined:
  - A cycle counter clears on every grant and on every burst end, and increments each cycle in GRANT.
  - When it reaches TIMEOUT_CYC-1 with no beat_i&&last_i that cycle, the grant is force-released exactly as on credit exhaustion (ptr advances, remaining credit is discarded).
  - timeout_o pulses high for the one cycle in which gnt_o drops.
  - If beat_i&&last_i occurs in the terminal count cycle, it takes priority and no timeout is flagged.
- Undefined: no counter is built, timeout_o is tied to 0, and a burst may stay in GRANT indefinitely.

Test Plan:
1. Reset, weights all 1, req_i=4'b1111, each burst is one beat with last=1 -> grant sequence 0,1,2,3,0. Each grant lasts 1 cycle, separated by 1 idle cycle. gnt_o=0 throughout reset.
2. weight port1=3, others 1, req_i=4'b0010 held, 4 single-beat bursts -> bursts 1-3 back-to-back with gnt_o=4'b0010 and no bubble. Release after burst 3 -> idle cycle -> regrant to port 1 with credit reloaded 3.
3. Port 2 granted, 5-beat burst with beat_i gaps; req_i[2] dropped after beat 1; req_i[0] raised mid-burst -> gnt_o=4'b0100 held until the beat with last. Next grant goes to port 0 after 1 idle cycle.
4. ptr=3 with req_i=4'b1001 -> port 3 wins. After its release -> port 0 wins (wrap-around).
5. weight_i port0=0 and req held -> treated as 1: a single burst, then release.
6. With WRR_BURST_TIMEOUT_EN and TIMEOUT_CYC=8: owner stalls with no last -> gnt_o drops and timeout_o=1 for 1 cycle, 8 cycles after the grant. Repeat with last on the 8th cycle -> normal release, timeout_o stays 0. Assert reset mid-burst -> gnt_o=0 on the next edge.
